// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 8-bit multicycle RISC core: sequences fetch/decode/
// execute/memory/write-back, drives datapath controls and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] ret_q;
  logic             retire;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= OP_R;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
      end
      if (retire) begin
        ret_q <= ret_q + CNT_ONE;
      end
    end
  end

  // Handshake: in FETCH, MEM_READ and MEM_WRITE the access completes in the
  // cycle mem_ready=1; otherwise the state and every output hold.
  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEM_WRITE;
        retire    = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign state   = state_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control words and
// retired counts are queued at drive time and compared when the outputs settle.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int W     = 21;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctl_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, ir_write, mem_read, mem_write;
  logic             i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] ret_q[$];
  logic [CNT_W-1:0] exp_ret;
  int               checks = 0;
  int               fails  = 0;
  int               cyc    = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic ctl_t exp_word(input logic [3:0] st, input logic rdy);
    ctl_t c;
    c    = '0;
    c.st = st;
    case (st)
      4'd0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      4'd1:  c.alu_src_b = 2'b11;
      4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      4'd4:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      4'd5:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      4'd9:  begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      4'd10: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd11: c.reg_write = 1'b1;
      4'd12: c.illegal_op = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] junk_op();
    return 6'($urandom_range(0, 63));
  endfunction

  // One clock cycle: drive inputs shortly after the edge, queue expectations,
  // compare once outputs settle, then advance past the next rising edge.
  task automatic step(input string tag, input logic [3:0] st, input logic [5:0] opc,
                      input logic rdy, input logic retire);
    logic [W-1:0]     obs, exp_w;
    logic [CNT_W-1:0] exp_r;
    opcode    = opc;
    mem_ready = rdy;
    exp_q.push_back(exp_word(st, rdy));
    ret_q.push_back(exp_ret);
    #3;
    obs   = {state, pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
             reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
             illegal_op};
    exp_w = exp_q.pop_front();
    exp_r = ret_q.pop_front();
    checks++;
    if (obs !== exp_w) begin
      fails++;
      $display("FAIL %s ctl cycle=%0d got=%h expected=%h", tag, cyc, obs, exp_w);
    end
    checks++;
    if (retired !== exp_r) begin
      fails++;
      $display("FAIL %s retired cycle=%0d got=%0d expected=%0d", tag, cyc, retired, exp_r);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (retire) exp_ret = exp_ret + 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    exp_ret = '0;
    step("reset_rdy1", 4'd0, 6'b100011, 1'b1, 1'b0);
    step("reset_rdy0", 4'd0, 6'b000000, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    step("lw", 4'd0, junk_op(), 1'b1, 1'b0);
    step("lw", 4'd1, 6'b100011, 1'b0, 1'b0);
    step("lw", 4'd2, 6'b101011, 1'b1, 1'b0);
    step("lw", 4'd3, junk_op(), 1'b1, 1'b0);
    step("lw", 4'd4, junk_op(), 1'b0, 1'b1);
  endtask

  task automatic test_r_stall();
    for (int i = 0; i < 3; i++) step("r_fetch_wait", 4'd0, junk_op(), 1'b0, 1'b0);
    step("r", 4'd0, junk_op(), 1'b1, 1'b0);
    step("r", 4'd1, 6'b000000, 1'b1, 1'b0);
    step("r", 4'd6, junk_op(), 1'b1, 1'b0);
    step("r", 4'd7, junk_op(), 1'b0, 1'b1);
  endtask

  task automatic test_beq_sw();
    step("beq", 4'd0, junk_op(), 1'b1, 1'b0);
    step("beq", 4'd1, 6'b000100, 1'b1, 1'b0);
    step("beq", 4'd8, junk_op(), 1'b1, 1'b1);
    step("sw", 4'd0, junk_op(), 1'b1, 1'b0);
    step("sw", 4'd1, 6'b101011, 1'b0, 1'b0);
    step("sw", 4'd2, 6'b100011, 1'b0, 1'b0);
    step("sw_wait", 4'd5, junk_op(), 1'b0, 1'b0);
    step("sw_wait", 4'd5, junk_op(), 1'b0, 1'b0);
    step("sw", 4'd5, junk_op(), 1'b1, 1'b1);
  endtask

  task automatic test_addi();
    step("addi", 4'd0, junk_op(), 1'b1, 1'b0);
    step("addi", 4'd1, 6'b001000, 1'b1, 1'b0);
    step("addi", 4'd10, junk_op(), 1'b1, 1'b0);
    step("addi", 4'd11, junk_op(), 1'b1, 1'b1);
  endtask

  task automatic test_illegal();
    step("illegal", 4'd0, junk_op(), 1'b1, 1'b0);
    step("illegal", 4'd1, 6'b111111, 1'b1, 1'b0);
    step("illegal", 4'd12, junk_op(), 1'b1, 1'b0);
    step("illegal", 4'd0, junk_op(), 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    step("mid_sw", 4'd0, junk_op(), 1'b1, 1'b0);
    step("mid_sw", 4'd1, 6'b101011, 1'b1, 1'b0);
    step("mid_sw", 4'd2, junk_op(), 1'b1, 1'b0);
    mem_ready = 1'b0;
    #2;
    checks++;
    if (mem_write !== 1'b1 || retired !== exp_ret) begin
      fails++;
      $display("FAIL mid_before mem_write=%b retired=%0d expected mem_write=1 retired=%0d",
               mem_write, retired, exp_ret);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || reg_write !== 1'b0 || state !== 4'd0 || retired !== '0) begin
      fails++;
      $display("FAIL mid_reset mem_write=%b reg_write=%b state=%0d retired=%0d expected 0 0 0 0",
               mem_write, reg_write, state, retired);
    end
    exp_ret = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      step("jump", 4'd0, junk_op(), 1'b1, 1'b0);
      step("jump", 4'd1, 6'b000010, 1'($urandom_range(0, 1)), 1'b0);
      step("jump", 4'd9, junk_op(), 1'($urandom_range(0, 1)), 1'b1);
    end
    step("jump_wrap", 4'd0, junk_op(), 1'b0, 1'b0);
  endtask

  initial begin
    opcode    = 6'd0;
    mem_ready = 1'b1;
    exp_ret   = '0;
    #1;
    test_reset();
    test_lw();
    test_r_stall();
    test_beq_sw();
    test_addi();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM of the 8-bit RISC processor, directly upstream of `alu_control`. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives the datapath enables, the mux selects and the 2-bit `alu_op` that `alu_control` decodes together with `fcode`. Stalls on a memory ready handshake and counts retired instructions.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instruction opcode from the IR; sampled only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle; ignored outside FETCH, MEM_READ and MEM_WRITE.
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `i_or_d`, `reg_write`, `reg_dst`, `mem_to_reg`, `alu_src_a` out 1: datapath controls.
- `alu_src_b` out 2: 00 = reg B, 01 = constant increment, 10 = sign-extended immediate, 11 = branch offset.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = use funct. Goes to `alu_control`.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.
- `state` out 4: current state, for debug.
- `retired` out `CNT_W`: count of completed instructions.

## Operation
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000. Every other value is illegal.
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, ILLEGAL 12. Values 13–15 go to FETCH.
- All outputs default to 0. Each state sets only the outputs listed below.
- FETCH:
  - Sets `mem_read`=1, `alu_src_b`=01, `alu_op`=00.
  - `ir_write` and `pc_write` are 1 only while `mem_ready`=1 (Mealy qualification).
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when it is 1.
- DECODE: sets `alu_src_b`=11, `alu_op`=00. Next state by opcode:
  - LW or SW → MEM_ADDR.
  - R → EXECUTE.
  - BEQ → BRANCH.
  - J → JUMP.
  - ADDI → ADDI_EX.
  - Any other opcode → ILLEGAL.
- MEM_ADDR: sets `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. LW → MEM_READ, SW → MEM_WRITE. The opcode used here is the one registered in DECODE.
- MEM_READ: sets `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`=1, then → MEM_WB.
- MEM_WB: sets `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. → FETCH.
- MEM_WRITE: sets `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`=1, then → FETCH.
- EXECUTE: sets `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. → R_WB.
- R_WB: sets `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. → FETCH.
- BRANCH: sets `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. → FETCH.
- JUMP: sets `pc_write`=1, `pc_source`=10. → FETCH.
- ADDI_EX: sets `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. → ADDI_WB.
- ADDI_WB: sets `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. → FETCH.
- ILLEGAL: sets `illegal_op`=1 and nothing else (no register, memory or PC write). → FETCH.
- `retired` increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB.
  - It does not increment on a transition from ILLEGAL.
  - It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `state`=FETCH and `retired`=0.
  - Outputs take their FETCH values: `mem_read`=1, `alu_src_b`=01, all others 0.
  - `pc_write` and `ir_write` follow `mem_ready`.
- Reset mid-instruction abandons the instruction: `mem_write` and `reg_write` drop in the same cycle, and the instruction is not counted.
- Cycle counts with zero wait states (`mem_ready` tied to 1):
  - LW 5 cycles.
  - SW, R and ADDI 4 cycles.
  - BEQ and J 3 cycles.
  - Illegal 3 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. All outputs hold steady during a stall.
- `mem_ready`=1 in any other state has no effect.
- `opcode` changes outside DECODE have no effect on the instruction in flight.

## Test plan
- Reset with `mem_ready`=1, then opcode 100011 (LW):
  - State sequence 0, 1, 2, 3, 4, 0.
  - `reg_write`=1 and `mem_to_reg`=1 in cycle 5.
  - `retired`=1 afterwards.
- R-type (000000) with `mem_ready` held 0 for 3 cycles in FETCH:
  - FETCH lasts 4 cycles; `ir_write` rises only in the 4th.
  - `alu_op`=10 in EXECUTE; `reg_dst`=1 in R_WB.
  - Total 7 cycles.
- BEQ (000100):
  - BRANCH state shows `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - SW (101011) then shows `mem_write`=1 held through 2 wait cycles, with `retired` incrementing once per instruction.
- Opcode 111111:
  - States 0, 1, 12, 0.
  - `illegal_op` pulses for exactly one cycle.
  - No write enables asserted; `retired` unchanged.
- Deassert `rst_n` during MEM_WRITE:
  - `mem_write` drops to 0 asynchronously.
  - `state`=0 and `retired`=0 immediately.
- `CNT_W`=4, 16 back-to-back J instructions: `retired` wraps 15 → 0.
